// File: rtl/ppi_bus_master_pkg.sv
// Shared constants for the 8255 PPI bus master: register addresses, control words,
// FSM state encodings and a helper for building bit set/reset (BSR) control words.
package ppi_pkg;

    localparam logic [1:0] PPI_PORTA = 2'b00;
    localparam logic [1:0] PPI_PORTB = 2'b01;
    localparam logic [1:0] PPI_PORTC = 2'b10;
    localparam logic [1:0] PPI_CTRL  = 2'b11;

    // Mode 0, ports A, B and C all inputs
    localparam logic [7:0] CW_ALL_INPUT = 8'h9B;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_STROBE  = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_RECOVER = 3'd4;
    localparam logic [2:0] ST_INIT    = 3'd5;

    localparam int unsigned TMR_W = 8;

    // Port C bit set/reset word: bit 7 clear selects BSR mode on the 8255
    function automatic logic [7:0] bsr_word(input logic [2:0] bit_idx, input logic set);
        return {4'b0000, bit_idx, set};
    endfunction

endpackage

// File: rtl/ppi_bus_master_if.sv
// Request/response handshake plus 8255 strobe/address lines of the PPI bus master.
// The bidirectional data bus stays a plain port on the master so its tri-state driver is local.
interface ppi_bus_master_if;

    logic       req_valid;
    logic       req_ready;
    logic       req_rnw;
    logic [1:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic [1:0] a0_a1;

    modport master (
        input  req_valid, req_rnw, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output cs_n, rd_n, wr_n, a0_a1
    );

    modport slave (
        output req_valid, req_rnw, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  cs_n, rd_n, wr_n, a0_a1
    );

endinterface

// File: rtl/ppi_bus_master_timer.sv
// Loadable down-counter shared by every bus phase; done is high while the count is zero.
module ppi_bus_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/ppi_bus_master.sv
// CPU-side 8255 PPI bus initiator: one request -> one cs/rd/wr cycle with programmable phases.
// Optional PPI_INIT_SEQ_EN: after reset, write CW_ALL_INPUT to the control register before accepting.
module ppi_bus_master
    import ppi_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned STROBE_CYC  = 2,
    parameter int unsigned HOLD_CYC    = 1,
    parameter int unsigned RECOVER_CYC = 1
) (
    input  logic              clk,
    input  logic              reset,
    ppi_bus_master_if.master  bus,
    inout  wire  [7:0]        data
);

`ifdef PPI_INIT_SEQ_EN
    localparam logic [2:0] RESET_STATE = ST_INIT;
    localparam logic       INIT_EN     = 1'b1;
`else
    localparam logic [2:0] RESET_STATE = ST_IDLE;
    localparam logic       INIT_EN     = 1'b0;
`endif

    // Each phase loads N-1 on entry and exits once the counter is back at zero
    localparam logic [TMR_W-1:0] LD_SETUP   = TMR_W'(SETUP_CYC - 1);
    localparam logic [TMR_W-1:0] LD_STROBE  = TMR_W'(STROBE_CYC - 1);
    localparam logic [TMR_W-1:0] LD_HOLD    = TMR_W'(HOLD_CYC - 1);
    localparam logic [TMR_W-1:0] LD_RECOVER = (RECOVER_CYC == 0) ? '0 : TMR_W'(RECOVER_CYC - 1);

    logic [2:0]       state_q, state_d;
    logic             rnw_q, rnw_n;
    logic [1:0]       addr_q, addr_n;
    logic [7:0]       wdata_q, wdata_n;
    logic             illegal;
    logic             tmr_load, tmr_done;
    logic [TMR_W-1:0] tmr_val;

    logic             cs_n_q, rd_n_q, wr_n_q, drive_q;
    logic [1:0]       a_q;
    logic             ready_q, rsp_valid_q, rsp_err_q, init_q;
    logic [7:0]       rdata_q;

    ppi_bus_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_d  = state_q;
        rnw_n    = rnw_q;
        addr_n   = addr_q;
        wdata_n  = wdata_q;
        illegal  = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && ready_q) begin
                    if (bus.req_rnw && bus.req_addr == PPI_CTRL) begin
                        illegal = 1'b1;
                    end else begin
                        rnw_n    = bus.req_rnw;
                        addr_n   = bus.req_addr;
                        wdata_n  = bus.req_wdata;
                        state_d  = ST_SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = LD_SETUP;
                    end
                end
            end
            ST_INIT: begin
                rnw_n    = 1'b0;
                addr_n   = PPI_CTRL;
                wdata_n  = CW_ALL_INPUT;
                state_d  = ST_SETUP;
                tmr_load = 1'b1;
                tmr_val  = LD_SETUP;
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    state_d  = ST_STROBE;
                    tmr_load = 1'b1;
                    tmr_val  = LD_STROBE;
                end
            end
            ST_STROBE: begin
                if (tmr_done) begin
                    state_d  = ST_HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = LD_HOLD;
                end
            end
            ST_HOLD: begin
                if (tmr_done) begin
                    if (RECOVER_CYC == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d  = ST_RECOVER;
                        tmr_load = 1'b1;
                        tmr_val  = LD_RECOVER;
                    end
                end
            end
            ST_RECOVER: begin
                if (tmr_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so every pin comes straight from a flop
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            rnw_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            drive_q     <= 1'b0;
            a_q         <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
            init_q      <= INIT_EN;
        end else begin
            state_q     <= state_d;
            rnw_q       <= rnw_n;
            addr_q      <= addr_n;
            wdata_q     <= wdata_n;
            ready_q     <= (state_d == ST_IDLE);
            rsp_valid_q <= 1'b0;

            if (state_q == ST_IDLE) begin
                init_q <= 1'b0;
            end

            if (illegal) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
                rdata_q     <= '0;
            end

            // The edge that ends the last strobe cycle both samples read data and opens HOLD
            if (state_q == ST_STROBE && state_d == ST_HOLD && !init_q) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b0;
                rdata_q     <= rnw_q ? data : '0;
            end

            case (state_d)
                ST_SETUP: begin
                    cs_n_q  <= 1'b0;
                    rd_n_q  <= 1'b1;
                    wr_n_q  <= 1'b1;
                    a_q     <= addr_n;
                    drive_q <= !rnw_n;
                end
                ST_STROBE: begin
                    cs_n_q  <= 1'b0;
                    rd_n_q  <= !rnw_n;
                    wr_n_q  <= rnw_n;
                    drive_q <= !rnw_n;
                end
                ST_HOLD: begin
                    cs_n_q  <= 1'b0;
                    rd_n_q  <= 1'b1;
                    wr_n_q  <= 1'b1;
                    drive_q <= !rnw_n;
                end
                default: begin
                    cs_n_q  <= 1'b1;
                    rd_n_q  <= 1'b1;
                    wr_n_q  <= 1'b1;
                    drive_q <= 1'b0;
                end
            endcase
        end
    end

    assign data = drive_q ? wdata_q : 'z;

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.cs_n      = cs_n_q;
    assign bus.rd_n      = rd_n_q;
    assign bus.wr_n      = wr_n_q;
    assign bus.a0_a1     = a_q;

endmodule

// File: tb/tb_ppi_bus_master.sv
// Bench for ppi_bus_master: a per-cycle timeline model of bus transfers checked every cycle,
// directed transfers pinned with literal waveforms, then randomized traffic with random resets.
module tb_ppi_bus_master;
    import ppi_pkg::*;

    localparam int unsigned S  = 1;
    localparam int unsigned ST = 2;
    localparam int unsigned H  = 1;
    localparam int unsigned R  = 1;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    wire  [7:0] data;
    logic       tb_en  = 1'b0;
    logic [7:0] tb_drv = 8'h00;

    assign data = tb_en ? tb_drv : 'z;

    ppi_bus_master_if bus ();

    ppi_bus_master #(
        .SETUP_CYC   (S),
        .STROBE_CYC  (ST),
        .HOLD_CYC    (H),
        .RECOVER_CYC (R)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master),
        .data  (data)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // One expected cycle of outputs
    typedef struct {
        bit         ready;
        bit         cs_n;
        bit         rd_n;
        bit         wr_n;
        bit         drv;
        bit         rv;
        bit         err;
        bit         cap;
        bit         use_cap;
        bit         has_a;
        logic [1:0] a;
        logic [7:0] wd;
    } ent_t;

    ent_t       q[$];
    ent_t       cur;
    bit         started   = 1'b0;
    bit         force_en  = 1'b0;
    logic [7:0] force_val = 8'h00;
    logic [7:0] drv_val   = 8'h00;
    logic [7:0] rd_cap    = 8'h00;
    logic [7:0] last_rdata = 8'h00;
    logic [1:0] last_addr  = 2'b00;

    function automatic ent_t idle_ent();
        ent_t e;
        e.ready = 1'b1; e.cs_n = 1'b1; e.rd_n = 1'b1; e.wr_n = 1'b1;
        e.drv = 1'b0; e.rv = 1'b0; e.err = 1'b0; e.cap = 1'b0; e.use_cap = 1'b0;
        e.has_a = 1'b0; e.a = 2'b00; e.wd = 8'h00;
        return e;
    endfunction

    // A transfer occupies S+ST+H+R cycles after its accept edge
    function automatic void push_xfer(input bit rnw, input logic [1:0] addr, input logic [7:0] wd,
                                      input bit with_rsp);
        ent_t e;
        for (int unsigned i = 0; i < S + ST + H + R; i++) begin
            e = idle_ent();
            e.ready = 1'b0; e.has_a = 1'b1; e.a = addr; e.wd = wd;
            if (i < S + ST + H) begin
                e.cs_n = 1'b0;
                e.drv  = !rnw;
            end
            if (i >= S && i < S + ST) begin
                e.rd_n = !rnw;
                e.wr_n = rnw;
                e.cap  = rnw && (i == S + ST - 1);
            end
            if (i == S + ST) begin
                e.rv      = with_rsp;
                e.use_cap = rnw;
            end
            q.push_back(e);
        end
    endfunction

    always begin
        ent_t e;
        @(posedge clk);
        #1;
        if (reset) begin
            q.delete();
            e = idle_ent();
            e.ready = 1'b0; e.has_a = 1'b1; e.a = 2'b00;
            q.push_back(e);
            last_rdata = 8'h00;
`ifdef PPI_INIT_SEQ_EN
            push_xfer(1'b0, PPI_CTRL, CW_ALL_INPUT, 1'b0);
`endif
            started = 1'b1;
        end else if (started) begin
            if (cur.cap) rd_cap = drv_val;
            if (bus.req_valid && cur.ready) begin
                if (bus.req_rnw && bus.req_addr == 2'b11) begin
                    e = idle_ent();
                    e.rv = 1'b1; e.err = 1'b1;
                    q.push_back(e);
                end else begin
                    push_xfer(bus.req_rnw, bus.req_addr, bus.req_wdata, 1'b1);
                end
            end
        end
        if (started) begin
            cur = (q.size() > 0) ? q.pop_front() : idle_ent();
            if (cur.has_a) last_addr = cur.a;
            if (cur.rv) last_rdata = cur.use_cap ? rd_cap : 8'h00;
            drv_val = force_en ? force_val : 8'($urandom);
            tb_drv  = drv_val;
            tb_en   = !cur.drv;
        end
        @(negedge clk);
        if (started) begin
            chk("req_ready", 16'(bus.req_ready), 16'(cur.ready));
            chk("cs_n",      16'(bus.cs_n),      16'(cur.cs_n));
            chk("rd_n",      16'(bus.rd_n),      16'(cur.rd_n));
            chk("wr_n",      16'(bus.wr_n),      16'(cur.wr_n));
            chk("a0_a1",     16'(bus.a0_a1),     16'(last_addr));
            chk("rsp_valid", 16'(bus.rsp_valid), 16'(cur.rv));
            if (cur.rv) chk("rsp_err", 16'(bus.rsp_err), 16'(cur.err));
            chk("rsp_rdata", 16'(bus.rsp_rdata), 16'(last_rdata));
            chk("data",      16'(data),          16'(cur.drv ? cur.wd : drv_val));
        end
    end

    logic [15:0] o_cs, o_rd, o_wr, o_rv, o_rdy, o_err;
    logic [7:0]  o_data  [16];
    logic [7:0]  o_rdata [16];
    logic [1:0]  o_a     [16];

    task automatic sample(input int unsigned i);
        o_cs[i]    = bus.cs_n;
        o_rd[i]    = bus.rd_n;
        o_wr[i]    = bus.wr_n;
        o_rv[i]    = bus.rsp_valid;
        o_rdy[i]   = bus.req_ready;
        o_err[i]   = bus.rsp_err;
        o_data[i]  = data;
        o_rdata[i] = bus.rsp_rdata;
        o_a[i]     = bus.a0_a1;
    endtask

    task automatic wait_ready();
        int unsigned n = 0;
        bus.req_valid = 1'b0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!bus.req_ready && n < 40);
        if (!bus.req_ready) chk("wait_ready timeout", 16'(bus.req_ready), 16'd1);
    endtask

    // Cycle 0 is the cycle whose closing edge accepts the request
    task automatic xfer(input bit rnw, input logic [1:0] addr, input logic [7:0] wd,
                        input bit two, input logic [7:0] wd2, input int unsigned rst_at);
        bus.req_valid = 1'b1;
        bus.req_rnw   = rnw;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #2;
            end
            if (i == 1) begin
                if (two) begin
                    bus.req_wdata = wd2;
                end else begin
                    bus.req_valid = 1'b0;
                    bus.req_rnw   = 1'($urandom);
                    bus.req_addr  = 2'($urandom);
                    bus.req_wdata = 8'($urandom);
                end
            end
            if (two && i == 7) bus.req_valid = 1'b0;
            if (rst_at != 0) reset = (i == rst_at);
            sample(i);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_rnw   = 1'b0;
        bus.req_addr  = 2'b00;
        bus.req_wdata = 8'h00;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;

`ifdef PPI_INIT_SEQ_EN
        for (int unsigned i = 0; i < 8; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #2;
            end
            sample(i);
        end
        chk("init req_ready", 16'(o_rdy[6:0]), 16'h0040);
        chk("init wr_n",      16'(o_wr[6:0]),  16'h0073);
        chk("init rsp_valid", 16'(o_rv[7:0]),  16'h0000);
        chk("init data",      16'(o_data[2]),  16'h009B);
        chk("init a0_a1",     16'(o_a[2]),     16'h0003);
`endif

        // Write 54 to port A
        wait_ready();
        xfer(1'b0, PPI_PORTA, 8'h54, 1'b0, 8'h00, 0);
        chk("t1 cs_n",      16'(o_cs[6:0]),  16'h0061);
        chk("t1 wr_n",      16'(o_wr[6:0]),  16'h0073);
        chk("t1 rd_n",      16'(o_rd[6:0]),  16'h007F);
        chk("t1 rsp_valid", 16'(o_rv[6:0]),  16'h0010);
        chk("t1 req_ready", 16'(o_rdy[6:0]), 16'h0041);
        for (int unsigned i = 1; i <= 4; i++) chk("t1 data", 16'(o_data[i]), 16'h0054);
        chk("t1 rsp_rdata", 16'(o_rdata[4]), 16'h0000);

        // Read port B while the bench holds A5 on the bus
        wait_ready();
        force_val = 8'hA5;
        force_en  = 1'b1;
        xfer(1'b1, PPI_PORTB, 8'h5A, 1'b0, 8'h00, 0);
        force_en  = 1'b0;
        chk("t2 rd_n",      16'(o_rd[6:0]),  16'h0073);
        chk("t2 wr_n",      16'(o_wr[6:0]),  16'h007F);
        chk("t2 rsp_valid", 16'(o_rv[6:0]),  16'h0010);
        chk("t2 rsp_rdata", 16'(o_rdata[4]), 16'h00A5);
        chk("t2 rsp_err",   16'(o_err[4]),   16'h0000);
        chk("t2 a0_a1",     16'(o_a[2]),     16'h0001);
        for (int unsigned i = 1; i <= 6; i++) chk("t2 data", 16'(o_data[i]), 16'h00A5);

        // Illegal read of the control register
        wait_ready();
        xfer(1'b1, PPI_CTRL, 8'h00, 1'b0, 8'h00, 0);
        chk("t3 cs_n",      16'(o_cs[6:0]),  16'h007F);
        chk("t3 rd_n",      16'(o_rd[6:0]),  16'h007F);
        chk("t3 rsp_valid", 16'(o_rv[6:0]),  16'h0002);
        chk("t3 rsp_err",   16'(o_err[1]),   16'h0001);
        chk("t3 rsp_rdata", 16'(o_rdata[1]), 16'h0000);

        // Back-to-back BSR writes: set PC0 then PC7
        wait_ready();
        xfer(1'b0, PPI_CTRL, bsr_word(3'd0, 1'b1), 1'b1, bsr_word(3'd7, 1'b1), 0);
        chk("t4 cs_n",      16'(o_cs[12:0]), 16'h1861);
        chk("t4 wr_n",      16'(o_wr[12:0]), 16'h1CF3);
        chk("t4 data 1st",  16'(o_data[2]),  16'h0001);
        chk("t4 data 2nd",  16'(o_data[8]),  16'h000F);
        chk("t4 a0_a1",     16'(o_a[8]),     16'h0003);

        // Reset during the second strobe cycle of a write
        wait_ready();
        xfer(1'b0, PPI_PORTC, 8'hC3, 1'b0, 8'h00, 3);
        chk("t5 wr_n strobe", 16'(o_wr[3]),  16'h0000);
        chk("t5 cs_n",        16'(o_cs[4]),  16'h0001);
        chk("t5 wr_n",        16'(o_wr[4]),  16'h0001);
        chk("t5 rsp_valid",   16'(o_rv[7:4]), 16'h0000);
        chk("t5 req_ready",   16'(o_rdy[4]), 16'h0000);

        // Randomized traffic with occasional resets
        wait_ready();
        for (int unsigned n = 0; n < 800; n++) begin
            @(posedge clk);
            #2;
            reset         = ($urandom_range(0, 199) == 0);
            bus.req_valid = ($urandom_range(0, 9) < 6);
            bus.req_rnw   = 1'($urandom);
            bus.req_addr  = 2'($urandom);
            bus.req_wdata = 8'($urandom);
        end
        reset = 1'b0;
        bus.req_valid = 1'b0;
        repeat (12) @(posedge clk);
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
